// File: rtl/cnn_window_gen.sv
// Multi-channel KxK sliding-window generator with line buffers,
// configurable stride, valid/ready backpressure and frame-last flag.
module cnn_window_gen #(
   parameter int CI     = 3,
   parameter int IBW    = 19,
   parameter int KX     = 5,
   parameter int KY     = 5,
   parameter int COLS   = 12,
   parameter int ROWS   = 12,
   parameter int STRIDE = 1
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        i_in_valid,
   output logic                        o_in_ready,
   input  logic [CI*IBW-1:0]           i_in_fmap,
   output logic                        o_ot_valid,
   input  logic                        i_ot_ready,
   output logic [CI*KY*KX*IBW-1:0]     o_ot_window,
   output logic [$clog2(ROWS)-1:0]     o_ot_row,
   output logic [$clog2(COLS)-1:0]     o_ot_col,
   output logic                        o_ot_last
);

   localparam int RW     = $clog2(ROWS);
   localparam int CW     = $clog2(COLS);
   localparam int WW     = CI*KY*KX*IBW;
   localparam int NR     = (ROWS-KY)/STRIDE + 1;
   localparam int NC     = (COLS-KX)/STRIDE + 1;
   localparam int LAST_R = KY-1 + (NR-1)*STRIDE;
   localparam int LAST_C = KX-1 + (NC-1)*STRIDE;
   localparam logic RPAR = 1'((KY-1) % 2);
   localparam logic CPAR = 1'((KX-1) % 2);

   logic [RW-1:0]  row_q, row_d, orow_q, orow_d;
   logic [CW-1:0]  col_q, col_d, ocol_q, ocol_d;
   logic           valid_q, valid_d, last_q, last_d;
   logic [WW-1:0]  win_q, win_d;
   logic [IBW-1:0] lb_q [CI][KY-1][COLS];
   logic           acc, qual, row_ok, col_ok;

   assign o_in_ready  = !valid_q || i_ot_ready;
   assign acc         = i_in_valid && o_in_ready;
   assign o_ot_valid  = valid_q;
   assign o_ot_window = win_q;
   assign o_ot_row    = orow_q;
   assign o_ot_col    = ocol_q;
   assign o_ot_last   = last_q;

   // Stride is 1 or 2, so the phase test reduces to a parity compare.
   assign row_ok = (row_q >= RW'(KY-1)) &&
                   (STRIDE == 1 || row_q[0] == RPAR);
   assign col_ok = (col_q >= CW'(KX-1)) &&
                   (STRIDE == 1 || col_q[0] == CPAR);
   assign qual   = acc && row_ok && col_ok;

   always_comb begin
      row_d   = row_q;
      col_d   = col_q;
      orow_d  = orow_q;
      ocol_d  = ocol_q;
      last_d  = last_q;
      win_d   = win_q;
      valid_d = valid_q && !i_ot_ready;
      if (acc) begin
         for (int c = 0; c < CI; c++) begin
            for (int ky = 0; ky < KY; ky++) begin
               for (int kx = 0; kx < KX-1; kx++) begin
                  win_d[((c*KY+ky)*KX+kx)*IBW +: IBW] =
                     win_q[((c*KY+ky)*KX+kx+1)*IBW +: IBW];
               end
            end
            for (int ky = 0; ky < KY-1; ky++) begin
               win_d[((c*KY+ky)*KX+KX-1)*IBW +: IBW] = lb_q[c][ky][col_q];
            end
            win_d[((c*KY+KY-1)*KX+KX-1)*IBW +: IBW] = i_in_fmap[c*IBW +: IBW];
         end
         if (col_q == CW'(COLS-1)) begin
            col_d = '0;
            row_d = (row_q == RW'(ROWS-1)) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
      if (qual) begin
         valid_d = 1'b1;
         orow_d  = row_q - RW'(KY-1);
         ocol_d  = col_q - CW'(KX-1);
         last_d  = (row_q == RW'(LAST_R)) && (col_q == CW'(LAST_C));
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         row_q   <= '0;
         col_q   <= '0;
         orow_q  <= '0;
         ocol_q  <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
         win_q   <= '0;
      end else begin
         row_q   <= row_d;
         col_q   <= col_d;
         orow_q  <= orow_d;
         ocol_q  <= ocol_d;
         last_q  <= last_d;
         valid_q <= valid_d;
         win_q   <= win_d;
      end
   end

   // Line buffers need no reset; qualification never exposes stale lines.
   always_ff @(posedge clk) begin
      if (acc) begin
         for (int c = 0; c < CI; c++) begin
            for (int l = 0; l < KY-2; l++) begin
               lb_q[c][l][col_q] <= lb_q[c][l+1][col_q];
            end
            lb_q[c][KY-2][col_q] <= i_in_fmap[c*IBW +: IBW];
         end
      end
   end

endmodule
